// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Load/store sequencer between the 64-bit MIPS datapath and a slow unified
//   memory that answers with a ready handshake. One CPU request becomes a
//   single-cycle memread/memwrite strobe. The unit then waits for ready to
//   drop and rise again, and aligns and extends the returned data. A halfword
//   store becomes two byte writes. Misaligned requests are rejected without
//   touching memory.
//
//   Ports
//     clk, rst_n            clock, asynchronous active-low reset
//     req/we/size/uns       CPU request: store flag, size (0 B,1 H,2 W,3 D),
//                           zero-extend flag for loads
//     addr/wdata            byte address, right-justified store data
//     rdata                 extended load result, held until the next load
//     busy/done/misalign    CPU status: stall, completion pulse, reject pulse
//     memread/memwrite      memory strobes; memwrite 0 none,1 word,2 byte,3 dword
//     dword                 memory 64-bit read select
//     dataadr/writedata     memory address and store data
//     readdata/ready        memory read data and idle/data-valid flag
module mem_access_unit #(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req,
    input  logic         we,
    input  logic [1:0]   size,
    input  logic         uns,
    input  logic [N-1:0] addr,
    input  logic [N-1:0] wdata,
    output logic [N-1:0] rdata,
    output logic         busy,
    output logic         done,
    output logic         misalign,
    output logic         memread,
    output logic [1:0]   memwrite,
    output logic         dword,
    output logic [N-1:0] dataadr,
    output logic [N-1:0] writedata,
    input  logic [N-1:0] readdata,
    input  logic         ready
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ISSUE    = 3'd1,
        S_WAIT_LO  = 3'd2,
        S_WAIT_HI  = 3'd3,
        S_ISSUE2   = 3'd4,
        S_WAIT_LO2 = 3'd5,
        S_WAIT_HI2 = 3'd6
    } state_t;

    state_t         state_q, state_d;
    logic           we_q, we_d;
    logic [1:0]     size_q, size_d;
    logic           uns_q, uns_d;
    logic [1:0]     addr_lo_q, addr_lo_d;
    logic [7:0]     sh_lo_q, sh_lo_d;      // second byte of a halfword store
    logic [N-1:0]   rdata_q, rdata_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           misalign_q, misalign_d;
    logic           memread_q, memread_d;
    logic [1:0]     memwrite_q, memwrite_d;
    logic           dword_q, dword_d;
    logic [N-1:0]   dataadr_q, dataadr_d;
    logic [N-1:0]   writedata_q, writedata_d;

    // Natural alignment: an access of 2^size bytes must start on a multiple of it.
    function automatic logic is_misaligned(input logic [1:0] sz, input logic [2:0] a_lo);
        logic r;
        case (sz)
            2'd1:    r = (a_lo[0] != 1'b0);
            2'd2:    r = (a_lo[1:0] != 2'b00);
            2'd3:    r = (a_lo != 3'b000);
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // Memory write code; a halfword goes out as byte writes.
    function automatic logic [1:0] store_code(input logic [1:0] sz);
        logic [1:0] c;
        case (sz)
            2'd2:    c = 2'd1;
            2'd3:    c = 2'd3;
            default: c = 2'd2;
        endcase
        return c;
    endfunction

    // Data for the first (or only) write; a halfword sends its high byte first.
    function automatic logic [N-1:0] store_data(input logic [1:0] sz, input logic [N-1:0] d);
        logic [N-1:0] r;
        case (sz)
            2'd0:    r = {{(N-8){1'b0}}, d[7:0]};
            2'd1:    r = {{(N-8){1'b0}}, d[15:8]};
            2'd2:    r = {{(N-32){1'b0}}, d[31:0]};
            default: r = d;
        endcase
        return r;
    endfunction

    // Big-endian lane selection inside the returned word, then sign/zero extension.
    function automatic logic [N-1:0] load_result(input logic [N-1:0] rd, input logic [1:0] sz,
                                                 input logic u, input logic [1:0] a_lo);
        logic [31:0]  word;
        logic [15:0]  half;
        logic [7:0]   byt;
        logic [N-1:0] r;
        word = rd[31:0];
        case (a_lo)
            2'd0:    byt = word[31:24];
            2'd1:    byt = word[23:16];
            2'd2:    byt = word[15:8];
            default: byt = word[7:0];
        endcase
        half = a_lo[1] ? word[15:0] : word[31:16];
        case (sz)
            2'd0:    r = {{(N-8){byt[7] & ~u}}, byt};
            2'd1:    r = {{(N-16){half[15] & ~u}}, half};
            2'd2:    r = {{(N-32){word[31] & ~u}}, word};
            default: r = rd;
        endcase
        return r;
    endfunction

    // Next-state and next-output logic; strobes default low so they never last past one cycle.
    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        size_d      = size_q;
        uns_d       = uns_q;
        addr_lo_d   = addr_lo_q;
        sh_lo_d     = sh_lo_q;
        rdata_d     = rdata_q;
        busy_d      = busy_q;
        dataadr_d   = dataadr_q;
        writedata_d = writedata_q;
        done_d      = 1'b0;
        misalign_d  = 1'b0;
        memread_d   = 1'b0;
        memwrite_d  = 2'b00;
        dword_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                // ready low means memory is still finishing an op from before a reset.
                if (req && ready) begin
                    if (is_misaligned(size, addr[2:0])) begin
                        misalign_d = 1'b1;
                    end else begin
                        state_d   = S_ISSUE;
                        busy_d    = 1'b1;
                        we_d      = we;
                        size_d    = size;
                        uns_d     = uns;
                        addr_lo_d = addr[1:0];
                        sh_lo_d   = wdata[7:0];
                        dataadr_d = addr;
                        if (we) begin
                            memwrite_d  = store_code(size);
                            writedata_d = store_data(size, wdata);
                        end else begin
                            memread_d = 1'b1;
                            dword_d   = (size == 2'd3);
                        end
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE:  state_d = S_WAIT_LO;
            S_WAIT_LO: begin
                if (!ready) begin
                    state_d = S_WAIT_HI;
                end else begin
                    state_d = S_WAIT_LO;
                end
            end
            S_WAIT_HI: begin
                if (ready) begin
                    if (we_q && (size_q == 2'd1)) begin
                        state_d     = S_ISSUE2;
                        memwrite_d  = 2'd2;
                        dataadr_d   = dataadr_q + {{(N-1){1'b0}}, 1'b1};
                        writedata_d = {{(N-8){1'b0}}, sh_lo_q};
                    end else begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        if (!we_q) begin
                            rdata_d = load_result(readdata, size_q, uns_q, addr_lo_q);
                        end else begin
                            rdata_d = rdata_q;
                        end
                    end
                end else begin
                    state_d = S_WAIT_HI;
                end
            end
            S_ISSUE2: state_d = S_WAIT_LO2;
            S_WAIT_LO2: begin
                if (!ready) begin
                    state_d = S_WAIT_HI2;
                end else begin
                    state_d = S_WAIT_LO2;
                end
            end
            S_WAIT_HI2: begin
                if (ready) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_WAIT_HI2;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset drops any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            we_q        <= 1'b0;
            size_q      <= 2'd0;
            uns_q       <= 1'b0;
            addr_lo_q   <= 2'd0;
            sh_lo_q     <= 8'd0;
            rdata_q     <= {N{1'b0}};
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            misalign_q  <= 1'b0;
            memread_q   <= 1'b0;
            memwrite_q  <= 2'b00;
            dword_q     <= 1'b0;
            dataadr_q   <= {N{1'b0}};
            writedata_q <= {N{1'b0}};
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            addr_lo_q   <= addr_lo_d;
            sh_lo_q     <= sh_lo_d;
            rdata_q     <= rdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            misalign_q  <= misalign_d;
            memread_q   <= memread_d;
            memwrite_q  <= memwrite_d;
            dword_q     <= dword_d;
            dataadr_q   <= dataadr_d;
            writedata_q <= writedata_d;
        end
    end

    assign rdata     = rdata_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign misalign  = misalign_q;
    assign memread   = memread_q;
    assign memwrite  = memwrite_q;
    assign dword     = dword_q;
    assign dataadr   = dataadr_q;
    assign writedata = writedata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: a 20-count ready memory, a byte-array reference
// model of the expected CPU-visible behaviour, a per-cycle compare process,
// directed cases with literal expectations, then randomized traffic.
module tb_mem_access_unit;
    localparam int N = 64;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req = 1'b0;
    logic         we = 1'b0;
    logic [1:0]   size = 2'd0;
    logic         uns = 1'b0;
    logic [N-1:0] addr = '0;
    logic [N-1:0] wdata = '0;
    logic [N-1:0] rdata;
    logic         busy, done, misalign, memread, dword;
    logic [1:0]   memwrite;
    logic [N-1:0] dataadr, writedata;
    logic [N-1:0] readdata = '0;
    logic         ready = 1'b1;

    mem_access_unit #(.N(N)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .size(size), .uns(uns),
        .addr(addr), .wdata(wdata), .rdata(rdata), .busy(busy), .done(done),
        .misalign(misalign), .memread(memread), .memwrite(memwrite), .dword(dword),
        .dataadr(dataadr), .writedata(writedata), .readdata(readdata), .ready(ready)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
    endtask

    // ---------------- slow memory: 16 dwords, 20-negedge busy count ----------------
    logic [63:0] ram [0:15];
    int          mcnt = 0;
    logic [6:0]  m_adr;
    logic        m_rd, m_dw;
    logic [1:0]  m_wr;
    logic [63:0] m_wd;
    int          n_rd_cyc = 0;
    int          n_wr_cyc = 0;

    always @(negedge clk) begin
        if (memread) n_rd_cyc++;
        if (memwrite != 2'b00) n_wr_cyc++;
        if (mcnt > 0) begin
            mcnt--;
            if (mcnt == 0) begin
                if (m_rd) begin
                    if (m_dw) readdata = ram[m_adr[6:3]];
                    else readdata = {32'b0, m_adr[2] ? ram[m_adr[6:3]][31:0] : ram[m_adr[6:3]][63:32]};
                end
                case (m_wr)
                    2'd1: if (m_adr[2]) ram[m_adr[6:3]][31:0] = m_wd[31:0];
                          else ram[m_adr[6:3]][63:32] = m_wd[31:0];
                    2'd2: ram[m_adr[6:3]][8*(7-int'(m_adr[2:0])) +: 8] = m_wd[7:0];
                    2'd3: ram[m_adr[6:3]] = m_wd;
                    default: ;
                endcase
                ready = 1'b1;
            end
        end else if (memread || memwrite != 2'b00) begin
            m_adr = dataadr[6:0];
            m_rd  = memread;
            m_dw  = dword;
            m_wr  = memwrite;
            m_wd  = writedata;
            mcnt  = 20;
            ready = 1'b0;
        end
    end

    // ---------------- reference model: byte-addressed, big-endian ----------------
    logic [7:0] ref_mem [0:127];

    function automatic logic [63:0] ref_load(input logic [6:0] a, input logic [1:0] s, input logic u);
        int nb;
        logic [63:0] v;
        nb = 1 << s;
        v = 64'd0;
        for (int i = 0; i < nb; i++) v = (v << 8) | 64'(ref_mem[int'(a) + i]);
        if (!u && nb < 8 && v[8*nb-1]) v = v | ~((64'd1 << (8*nb)) - 64'd1);
        return v;
    endfunction

    function automatic logic [63:0] ref_wdata(input logic [1:0] s, input logic [63:0] d);
        int nb;
        nb = 1 << s;
        if (s == 2'd1) return 64'(d[15:8]);
        if (nb == 8) return d;
        return d & ((64'd1 << (8*nb)) - 64'd1);
    endfunction

    function automatic logic [1:0] ref_wcode(input logic [1:0] s);
        if (s == 2'd2) return 2'd1;
        if (s == 2'd3) return 2'd3;
        return 2'd2;
    endfunction

    int          cyc = 0;
    bit          act = 0;
    int          t0 = 0;
    int          tlen = 0;
    logic        x_we, x_uns;
    logic [1:0]  x_sz;
    logic [6:0]  x_a;
    logic [63:0] x_d, x_ld;
    logic        e_busy = 0, e_done = 0, e_mis = 0, e_rd = 0, e_dw = 0;
    logic [1:0]  e_wr = 0;
    logic [63:0] e_adr = 0, e_wdat = 0, e_rdata = 0;

    // Expected outputs for the interval following each rising edge.
    always @(posedge clk) begin
        cyc++;
        e_done = 0; e_mis = 0; e_rd = 0; e_wr = 2'd0; e_dw = 0;
        if (!rst_n) begin
            act = 0; e_busy = 0; e_rdata = 64'd0;
        end else if (act && cyc == t0 + tlen) begin
            act = 0; e_busy = 0; e_done = 1;
            if (!x_we) e_rdata = x_ld;
        end else if (act) begin
            if (x_we && x_sz == 2'd1 && cyc == t0 + 21) begin
                e_wr = 2'd2; e_adr = 64'(x_a) + 64'd1; e_wdat = 64'(x_d[7:0]);
            end
        end else if (req && ready) begin
            if ((int'(addr[6:0]) % (1 << size)) != 0) begin
                e_mis = 1;
            end else begin
                act = 1; t0 = cyc; tlen = (we && size == 2'd1) ? 42 : 21;
                x_we = we; x_sz = size; x_uns = uns; x_a = addr[6:0]; x_d = wdata;
                e_busy = 1; e_adr = 64'(x_a);
                if (we) begin
                    e_wr = ref_wcode(size); e_wdat = ref_wdata(size, wdata);
                    for (int i = 0; i < (1 << size); i++)
                        ref_mem[int'(x_a) + i] = x_d[8*((1 << size) - 1 - i) +: 8];
                end else begin
                    e_rd = 1; e_dw = (size == 2'd3); x_ld = ref_load(x_a, size, uns);
                end
            end
        end
    end

    // Per-cycle compare, away from the active edge.
    bit chk_en = 0;
    always @(negedge clk) begin
        if (chk_en) begin
            if (!rst_n) begin
                chk("rst_busy", 64'(busy), 64'd0);
                chk("rst_done", 64'(done), 64'd0);
                chk("rst_memread", 64'(memread), 64'd0);
                chk("rst_memwrite", 64'(memwrite), 64'd0);
                chk("rst_rdata", rdata, 64'd0);
                chk("rst_dataadr", dataadr, 64'd0);
                chk("rst_writedata", writedata, 64'd0);
            end else begin
                chk("busy", 64'(busy), 64'(e_busy));
                chk("done", 64'(done), 64'(e_done));
                chk("misalign", 64'(misalign), 64'(e_mis));
                chk("memread", 64'(memread), 64'(e_rd));
                chk("memwrite", 64'(memwrite), 64'(e_wr));
                chk("rdata", rdata, e_rdata);
                if (e_rd || e_wr != 2'd0) begin
                    chk("dword", 64'(dword), 64'(e_dw));
                    chk("dataadr", dataadr, e_adr);
                    if (e_wr != 2'd0) chk("writedata", writedata, e_wdat);
                end
            end
        end
    end

    // ---------------- CPU-side driver ----------------
    task automatic do_op(input logic w, input logic [1:0] s, input logic u, input logic [6:0] a,
                         input logic [63:0] d, output bit was_mis);
        bit acc, fin;
        int c0;
        we = w; size = s; uns = u; addr = 64'(a); wdata = d; req = 1'b1;
        acc = 0; was_mis = 0; fin = 0; c0 = 0;
        for (int i = 0; i < 100 && !acc && !was_mis; i++) begin
            @(posedge clk); #1;
            if (busy) acc = 1;
            else if (misalign) was_mis = 1;
        end
        req = 1'b0;
        addr = {$urandom, $urandom}; wdata = {$urandom, $urandom};
        if (!acc && !was_mis) chk("accept_timeout", 64'd0, 64'd1);
        if (acc) begin
            c0 = cyc;
            for (int i = 0; i < 100 && !fin; i++) begin
                @(posedge clk); #1;
                if (done) fin = 1;
            end
            chk("done_seen", 64'(fin), 64'd1);
            chk("latency", 64'(cyc - c0), (w && s == 2'd1) ? 64'd42 : 64'd21);
        end
    endtask

    bit mis;
    int rd0, wr0;

    initial begin
        for (int i = 0; i < 16; i++) ram[i] = {$urandom, $urandom};
        ram[2] = 64'h11223344_8899AABB;
        for (int i = 0; i < 128; i++) ref_mem[i] = ram[i/8][8*(7 - i%8) +: 8];

        @(posedge clk); chk_en = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_rdata", rdata, 64'd0);
        chk("reset_memwrite", 64'(memwrite), 64'd0);
        rst_n = 1'b1;

        do_op(1'b0, 2'd0, 1'b0, 7'h14, 64'd0, mis);
        chk("lb_0x14", rdata, 64'hFFFF_FFFF_FFFF_FF88);
        do_op(1'b0, 2'd0, 1'b1, 7'h14, 64'd0, mis);
        chk("lbu_0x14", rdata, 64'h88);
        do_op(1'b0, 2'd1, 1'b0, 7'h16, 64'd0, mis);
        chk("lh_0x16", rdata, 64'hFFFF_FFFF_FFFF_AABB);
        do_op(1'b0, 2'd2, 1'b1, 7'h10, 64'd0, mis);
        chk("lwu_0x10", rdata, 64'h1122_3344);
        do_op(1'b0, 2'd3, 1'b0, 7'h10, 64'd0, mis);
        chk("ld_0x10", rdata, 64'h11223344_8899AABB);

        rd0 = n_rd_cyc; wr0 = n_wr_cyc;
        do_op(1'b1, 2'd1, 1'b0, 7'h12, 64'hBEEF, mis);
        chk("sh_ram", ram[2], 64'h1122BEEF_8899AABB);
        chk("sh_write_strobes", 64'(n_wr_cyc - wr0), 64'd2);
        chk("sh_read_strobes", 64'(n_rd_cyc - rd0), 64'd0);

        rd0 = n_rd_cyc;
        do_op(1'b0, 2'd2, 1'b0, 7'h12, 64'd0, mis);
        chk("lw_misalign", 64'(mis), 64'd1);
        chk("lw_mis_rdata_held", rdata, 64'h11223344_8899AABB);
        chk("lw_mis_no_read", 64'(n_rd_cyc - rd0), 64'd0);
        @(posedge clk); #1;
        chk("lw_mis_pulse_end", 64'(misalign), 64'd0);

        rd0 = n_rd_cyc; wr0 = n_wr_cyc;
        do_op(1'b1, 2'd2, 1'b0, 7'h18, 64'hCAFEF00D, mis);
        do_op(1'b0, 2'd2, 1'b0, 7'h18, 64'd0, mis);
        chk("sw_lw_0x18", rdata, 64'hFFFF_FFFF_CAFE_F00D);
        chk("sw_lw_wr_cycles", 64'(n_wr_cyc - wr0), 64'd1);
        chk("sw_lw_rd_cycles", 64'(n_rd_cyc - rd0), 64'd1);

        // Reset five cycles into a dword load; the memory keeps counting.
        we = 1'b0; size = 2'd3; uns = 1'b0; addr = 64'h10; req = 1'b1;
        for (int i = 0; i < 50 && !busy; i++) begin @(posedge clk); #1; end
        req = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_rdata", rdata, 64'd0);
        chk("midrst_ready_low", 64'(ready), 64'd0);
        rst_n = 1'b1;
        do_op(1'b0, 2'd0, 1'b1, 7'h14, 64'd0, mis);
        chk("after_rst_lbu", rdata, 64'h88);

        for (int k = 0; k < 60; k++) begin
            logic [1:0] s;
            logic [6:0] a;
            s = 2'($urandom_range(0, 3));
            a = 7'($urandom_range(0, 127));
            if ($urandom_range(0, 3) != 0) a = a & ~7'((1 << s) - 1);
            do_op(1'($urandom_range(0, 1)), s, 1'($urandom_range(0, 1)), a, {$urandom, $urandom}, mis);
        end

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
